// File: rtl/fp_norm_sequencer.sv
// Iterative normalizer between the FP adder's mantissa stage and result packing.
// Handles carry-out, leading-zero shifts bounded to STEP per cycle, underflow, zero and overflow.
module fp_norm_sequencer #(
  parameter int MAN_W = 24,
  parameter int EXP_W = 8,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W:0]   in_man,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_man,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_denorm,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, OUT = 2'd2} state_t;

  state_t           state_r, state_n;
  logic             sign_r, sign_n;
  logic [EXP_W-1:0] exp_r, exp_n;
  logic [MAN_W:0]   man_r, man_n;
  logic             zero_r, zero_n, ovf_r, ovf_n, denorm_r, denorm_n;

  logic [31:0]      lz_s, lim_s, exp_m1_s, sh_s;
  logic [EXP_W-1:0] exp_inc_s;

  function automatic logic [31:0] lzc(input logic [MAN_W-1:0] m);
    logic [31:0] n;
    logic        found;
    n     = 32'(MAN_W);
    found = 1'b0;
    for (int i = MAN_W - 1; i >= 0; i--) begin
      if (!found && m[i]) begin
        n     = 32'(MAN_W - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Shift distance is capped by STEP and by keeping the exponent at or above 1.
  assign lz_s      = lzc(man_r[MAN_W-1:0]);
  assign lim_s     = (lz_s < 32'(STEP)) ? lz_s : 32'(STEP);
  assign exp_m1_s  = 32'(exp_r) - 32'd1;
  assign sh_s      = (exp_m1_s < lim_s) ? exp_m1_s : lim_s;
  assign exp_inc_s = exp_r + EXP_W'(1);

  // Next-state and working-register update, one normalization rule per NORM cycle.
  always_comb begin
    state_n  = state_r;
    sign_n   = sign_r;
    exp_n    = exp_r;
    man_n    = man_r;
    zero_n   = zero_r;
    ovf_n    = ovf_r;
    denorm_n = denorm_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          sign_n   = in_sign;
          exp_n    = in_exp;
          man_n    = in_man;
          zero_n   = 1'b0;
          ovf_n    = 1'b0;
          denorm_n = 1'b0;
          state_n  = NORM;
        end else begin
          state_n  = IDLE;
        end
      end
      NORM: begin
        if (man_r[MAN_W]) begin
          exp_n   = exp_inc_s;
          state_n = OUT;
          if (exp_inc_s == {EXP_W{1'b1}}) begin
            man_n = '0;
            ovf_n = 1'b1;
          end else begin
            man_n = {1'b0, man_r[MAN_W:1]};
          end
        end else if (man_r[MAN_W-1:0] == '0) begin
          exp_n   = '0;
          zero_n  = 1'b1;
          state_n = OUT;
        end else if (lz_s == 32'd0) begin
          state_n = OUT;
        end else if (exp_r == '0) begin
          denorm_n = 1'b1;
          state_n  = OUT;
        end else if (exp_r == EXP_W'(1)) begin
          exp_n    = '0;
          denorm_n = 1'b1;
          state_n  = OUT;
        end else begin
          man_n   = man_r << sh_s;
          exp_n   = exp_r - EXP_W'(sh_s);
          state_n = NORM;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = OUT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and result registers; reset abandons any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      sign_r   <= 1'b0;
      exp_r    <= '0;
      man_r    <= '0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      denorm_r <= 1'b0;
    end else begin
      state_r  <= state_n;
      sign_r   <= sign_n;
      exp_r    <= exp_n;
      man_r    <= man_n;
      zero_r   <= zero_n;
      ovf_r    <= ovf_n;
      denorm_r <= denorm_n;
    end
  end

  assign in_ready   = (state_r == IDLE);
  assign busy       = (state_r == NORM) || (state_r == OUT);
  assign out_valid  = (state_r == OUT);
  assign out_sign   = sign_r;
  assign out_exp    = exp_r;
  assign out_man    = man_r[MAN_W-1:0];
  assign out_zero   = zero_r;
  assign out_ovf    = ovf_r;
  assign out_denorm = denorm_r;

endmodule

// File: tb/tb_fp_norm_sequencer.sv
// Randomized and directed bench for fp_norm_sequencer against an arithmetic reference model.
module tb_fp_norm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_exp = 8'd0;
  logic [24:0] in_man = 25'd0;
  logic        in_ready, out_valid, out_sign, out_zero, out_ovf, out_denorm, busy;
  logic [7:0]  out_exp;
  logic [23:0] out_man;

  int checks = 0;
  int errors = 0;

  fp_norm_sequencer #(.MAN_W(24), .EXP_W(8), .STEP(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_exp(out_exp), .out_man(out_man), .out_zero(out_zero),
    .out_ovf(out_ovf), .out_denorm(out_denorm), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: apply the normalization rules with integer arithmetic; res packs {ovf,denorm,zero,sign,exp,man}.
  function automatic void model(input int sign, input int exp, input int man,
                                output logic [35:0] res, output int lat);
    int e, m, lz, s, n;
    bit z, o, d;
    e = exp; m = man; n = 0; z = 0; o = 0; d = 0;
    for (int k = 0; k < 64; k++) begin
      if (m >= (1 << 24)) begin
        m = m / 2; e = (e + 1) % 256;
        if (e == 255) begin m = 0; o = 1; end
        break;
      end
      if (m == 0) begin e = 0; z = 1; break; end
      if (m >= (1 << 23)) break;
      if (e == 0) begin d = 1; break; end
      if (e == 1) begin e = 0; d = 1; break; end
      lz = 0;
      while (m < ((1 << 23) >> lz)) lz++;
      s = lz;
      if (s > 4) s = 4;
      if (s > e - 1) s = e - 1;
      m = m * (1 << s); e = e - s; n++;
    end
    res = {o, d, z, 1'(sign), 8'(e), 24'(m)};
    lat = 2 + n;
  endfunction

  task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_man = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output bit ok);
    lat = 1; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [35:0] observed();
    return {out_ovf, out_denorm, out_zero, out_sign, out_exp, out_man};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001 || observed() !== 36'd0) begin
      errors++;
      $display("FAIL reset: valid/busy/ready=%b res=%h, required 001 and 0", {out_valid, busy, in_ready}, observed());
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [24:0] mans [6] = '{25'h0800000, 25'h0000001, 25'h1800001, 25'h1800001, 25'h0000000, 25'h0000100};
    logic [7:0]  exps [6] = '{8'd100, 8'd100, 8'd10, 8'd254, 8'd50, 8'd5};
    logic        sgns [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [35:0] want [6] = '{ {3'b000, 1'b0, 8'd100, 24'h800000}, {3'b000, 1'b0, 8'd77, 24'h800000},
                               {3'b000, 1'b0, 8'd11, 24'hC00000}, {3'b100, 1'b0, 8'd255, 24'h000000},
                               {3'b001, 1'b1, 8'd0, 24'h000000},  {3'b010, 1'b0, 8'd0, 24'h001000} };
    int          wlat [6] = '{2, 8, 2, 2, 2, 3};
    int lat;
    bit ok;
    for (int i = 0; i < 6; i++) begin
      send(sgns[i], exps[i], mans[i]);
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_busy: busy=%b in_ready=%b, required 1 0", i, busy, in_ready);
      end
      wait_valid(lat, ok);
      checks++;
      if (!ok || lat != wlat[i]) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d (ok=%0d), required %0d", i, lat, ok, wlat[i]);
      end
      checks++;
      if (observed() !== want[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got %h, required %h", i, observed(), want[i]);
      end
      consume();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_release: out_valid=%b in_ready=%b, required 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [35:0] exp_res;
    int exp_lat, lat;
    bit ok;
    logic [24:0] m;
    logic [7:0]  e;
    logic        s;
    for (int i = 0; i < 60; i++) begin
      m = 25'($urandom_range(0, 32'h1FFFFFF) >> $urandom_range(0, 25));
      e = 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      model(int'(s), int'(e), int'(m), exp_res, exp_lat);
      send(s, e, m);
      wait_valid(lat, ok);
      checks++;
      if (!ok || lat != exp_lat || observed() !== exp_res) begin
        errors++;
        $display("FAIL rand%0d: man=%h exp=%0d got lat=%0d res=%h, required lat=%0d res=%h",
                 i, m, e, lat, observed(), exp_lat, exp_res);
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      consume();
    end
  endtask

  task automatic test_hold();
    logic [35:0] held;
    int lat;
    bit ok;
    send(1'b1, 8'd120, 25'h0001234);
    wait_valid(lat, ok);
    held = observed();
    for (int c = 0; c < 5; c++) begin
      if (c == 2) in_valid = 1'b1;
      in_sign = 1'b0; in_exp = 8'd7; in_man = 25'h1000000;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (!ok || out_valid !== 1'b1 || in_ready !== 1'b0 || observed() !== held) begin
        errors++;
        $display("FAIL hold%0d: valid=%b ready=%b res=%h, required 1 0 %h", c, out_valid, in_ready, observed(), held);
      end
    end
    consume();
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_ignored: out_valid=%b busy=%b, required 0 0", out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [35:0] exp_res;
    int exp_lat, lat;
    bit ok;
    send(1'b0, 8'd100, 25'h0000001);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || observed() !== 36'd0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b ready=%b busy=%b res=%h, required 0 1 0 0", out_valid, in_ready, busy, observed());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model(0, 40, 32'h0000030, exp_res, exp_lat);
    send(1'b0, 8'd40, 25'h0000030);
    wait_valid(lat, ok);
    checks++;
    if (!ok || lat != exp_lat || observed() !== exp_res) begin
      errors++;
      $display("FAIL after_reset: lat=%0d res=%h, required lat=%0d res=%h", lat, observed(), exp_lat, exp_res);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 8'(20 + i), 25'h0400000);
      wait_valid(lat, ok);
      checks++;
      if (!ok || lat != 3 || out_exp !== 8'(19 + i) || out_man !== 24'h800000) begin
        errors++;
        $display("FAIL b2b%0d: lat=%0d exp=%0d man=%h, required 3 %0d 800000", i, lat, out_exp, out_man, 19 + i);
      end
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
